// File: rtl/button_ctrl_if.sv
// rtl/button_ctrl_if.sv - button/LED signal bundle between LA/IO glue and button_ctrl
interface button_ctrl_if;
    logic       enable_i;
    logic       btn_i;
    logic [2:0] led_o;
    logic [1:0] mode_o;
    logic       press_pulse_o;
    logic       long_pulse_o;
    logic [7:0] press_count_o;
    logic       btn_db_o;

    // Controller side
    modport slave (
        input  enable_i,
        input  btn_i,
        output led_o,
        output mode_o,
        output press_pulse_o,
        output long_pulse_o,
        output press_count_o,
        output btn_db_o
    );

    // Driver/observer side
    modport master (
        output enable_i,
        output btn_i,
        input  led_o,
        input  mode_o,
        input  press_pulse_o,
        input  long_pulse_o,
        input  press_count_o,
        input  btn_db_o
    );
endinterface

// File: rtl/button_ctrl.sv
// rtl/button_ctrl.sv - debounced push-button controller with OFF/ON/BLINK LED mode machine
module button_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int LONG_PRESS_CYCLES = 25000000,
    parameter int BLINK_HALF_CYCLES = 5000000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    button_ctrl_if.slave  bus
);

    localparam int DBW   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLDW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int BLW   = $clog2(BLINK_HALF_CYCLES);

    localparam logic [DBW-1:0]   DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLDW-1:0] HOLD_MAX  = HOLDW'(LONG_PRESS_CYCLES);
    localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(LONG_PRESS_CYCLES - 1);
    localparam logic [BLW-1:0]   BL_LAST   = BLW'(BLINK_HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2
    } mode_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_btn_db;
    logic             r_btn_db_q;
    logic [DBW-1:0]   r_db_cnt;
    logic [HOLDW-1:0] r_hold;
    logic             r_armed;
    mode_t            r_mode;
    mode_t            w_mode_next;
    logic             r_press_pulse;
    logic             r_long_pulse;
    logic [7:0]       r_press_count;
    logic [BLW-1:0]   r_blink_cnt;
    logic             r_phase;
    logic [2:0]       w_led;

    logic w_rise;
    logic w_fall;
    logic w_long;
    logic w_short;

    assign w_rise = r_btn_db & ~r_btn_db_q;
    assign w_fall = ~r_btn_db & r_btn_db_q;

    // db_q gates out the rise cycle, where r_hold still carries the previous press
    assign w_long  = r_btn_db & r_btn_db_q & r_armed & bus.enable_i & (r_hold == HOLD_LAST);
    assign w_short = w_fall & r_armed & bus.enable_i & (r_hold < HOLD_LAST);

    // Two-flop synchroniser for the asynchronous button pin
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.btn_i;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: level follows the synchronised input only after a full run of disagreement
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_btn_db   <= 1'b0;
            r_btn_db_q <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_btn_db_q <= r_btn_db;
            if (r_sync2 != r_btn_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_btn_db <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Hold timer and press validity: armed only when enabled at press start, lost on any enable drop
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_hold  <= '0;
            r_armed <= 1'b0;
        end else begin
            if (w_rise) begin
                r_hold <= '0;
            end else if (r_btn_db && (r_hold != HOLD_MAX)) begin
                r_hold <= r_hold + 1'b1;
            end
            if (w_rise) begin
                r_armed <= bus.enable_i;
            end else begin
                r_armed <= r_armed & bus.enable_i & ~w_long & ~w_short;
            end
        end
    end

    // Mode state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_mode <= MODE_OFF;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // Mode next state: long press forces OFF, short press cycles OFF->ON->BLINK->OFF
    always_comb begin
        w_mode_next = r_mode;
        if (w_long) begin
            w_mode_next = MODE_OFF;
        end else if (w_short) begin
            case (r_mode)
                MODE_OFF: w_mode_next = MODE_ON;
                MODE_ON:  w_mode_next = MODE_BLINK;
                default:  w_mode_next = MODE_OFF;
            endcase
        end
    end

    // LED drive decoded from mode and blink phase
    always_comb begin
        w_led = 3'b000;
        case (r_mode)
            MODE_ON:    w_led = 3'b111;
            MODE_BLINK: w_led = {3{r_phase}};
            default:    w_led = 3'b000;
        endcase
    end

    // Event strobes and the wrapping short-press counter
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_press_pulse <= 1'b0;
            r_long_pulse  <= 1'b0;
            r_press_count <= 8'd0;
        end else begin
            r_press_pulse <= w_short;
            r_long_pulse  <= w_long;
            if (w_short) begin
                r_press_count <= r_press_count + 8'd1;
            end
        end
    end

    // Blink timebase: starts lit on entry, toggles every half period, parked at 0 otherwise
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_mode_next == MODE_BLINK && r_mode != MODE_BLINK) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_mode_next == MODE_BLINK) begin
            if (r_blink_cnt == BL_LAST) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end
    end

    assign bus.led_o         = w_led;
    assign bus.mode_o        = r_mode;
    assign bus.press_pulse_o = r_press_pulse;
    assign bus.long_pulse_o  = r_long_pulse;
    assign bus.press_count_o = r_press_count;
    assign bus.btn_db_o      = r_btn_db;

endmodule

// File: tb/tb_button_ctrl.sv
// tb/tb_button_ctrl.sv - self-checking bench for button_ctrl against a cycle-level behavioural model
module tb_button_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 16;
    localparam int HALF = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    button_ctrl_if bus();

    button_ctrl #(
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .BLINK_HALF_CYCLES(HALF)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int obs_press = 0;
    int obs_long  = 0;

    // Reference model state
    bit m_s1, m_s2, m_db, m_db_prev, m_valid, m_press, m_long;
    int m_dis, m_len, m_mode, m_count, m_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_db_prev = 0; m_valid = 0;
        m_press = 0; m_long = 0;
        m_dis = 0; m_len = 0; m_mode = 0; m_count = 0; m_t = 0;
    endtask

    // One clock edge of the spec's rules, using input values present at that edge
    task automatic model_step();
        bit en;
        bit ev_s;
        bit ev_l;
        int prev_mode;
        en   = bus.enable_i;
        ev_s = 0;
        ev_l = 0;
        if (m_db && !m_db_prev) begin
            m_len   = 1;
            m_valid = en;
        end else if (m_db) begin
            m_len++;
            if (m_len == LONG + 1 && m_valid && en) ev_l = 1;
            m_valid = m_valid && en && !ev_l;
        end else begin
            if (m_db_prev && m_len < LONG && m_valid && en) ev_s = 1;
            m_valid = m_valid && en && !ev_s;
        end
        m_press   = ev_s;
        m_long    = ev_l;
        prev_mode = m_mode;
        if (ev_l) begin
            m_mode = 0;
        end else if (ev_s) begin
            m_mode  = (m_mode + 1) % 3;
            m_count = (m_count + 1) % 256;
        end
        if (m_mode == 2) m_t = (prev_mode == 2) ? m_t + 1 : 0;
        else             m_t = 0;
        m_db_prev = m_db;
        if (m_s2 != m_db) begin
            if (m_dis == DEB - 1) begin
                m_db  = m_s2;
                m_dis = 0;
            end else begin
                m_dis++;
            end
        end else begin
            m_dis = 0;
        end
        m_s2 = m_s1;
        m_s1 = bus.btn_i;
    endtask

    function automatic logic [15:0] model_outs();
        logic [2:0] led;
        if (m_mode == 1)      led = 3'b111;
        else if (m_mode == 2) led = (((m_t / HALF) % 2) == 0) ? 3'b111 : 3'b000;
        else                  led = 3'b000;
        return {led, 2'(m_mode), m_press, m_long, 8'(m_count), m_db};
    endfunction

    function automatic logic [15:0] dut_outs();
        return {bus.led_o, bus.mode_o, bus.press_pulse_o, bus.long_pulse_o,
                bus.press_count_o, bus.btn_db_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
        if (bus.press_pulse_o) obs_press++;
        if (bus.long_pulse_o)  obs_long++;
        check("outs", 32'(dut_outs()), 32'(model_outs()));
        check("no_dual_pulse", 32'(bus.press_pulse_o & bus.long_pulse_o), 32'd0);
    endtask

    task automatic press(input int hi, input int lo);
        bus.btn_i = 1'b1;
        repeat (hi) tick();
        bus.btn_i = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async", 32'(dut_outs()), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    int p0, l0, c0, md0;

    initial begin
        bus.btn_i    = 1'b0;
        bus.enable_i = 1'b1;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset_mode", 32'(bus.mode_o), 32'd0);
        check("reset_led", 32'(bus.led_o), 32'd0);
        check("reset_count", 32'(bus.press_count_o), 32'd0);

        // Glitch shorter than the debounce window
        press(3, 10);
        check("glitch_db_cnt", 32'(obs_press + obs_long), 32'd0);
        check("glitch_mode", 32'(bus.mode_o), 32'd0);

        // First short press, with debounce latency probe
        bus.btn_i = 1'b1;
        repeat (5) tick();
        check("db_before_6", 32'(bus.btn_db_o), 32'd0);
        tick();
        check("db_at_6", 32'(bus.btn_db_o), 32'd1);
        repeat (4) tick();
        bus.btn_i = 1'b0;
        repeat (10) tick();
        check("p1_mode", 32'(bus.mode_o), 32'd1);
        check("p1_led", 32'(bus.led_o), 32'd7);
        check("p1_count", 32'(bus.press_count_o), 32'd1);

        // ON -> BLINK (watch a few half-periods) -> OFF
        press(10, 40);
        check("p2_mode", 32'(bus.mode_o), 32'd2);
        press(10, 10);
        check("p3_mode", 32'(bus.mode_o), 32'd0);
        check("p3_count", 32'(bus.press_count_o), 32'd3);

        // Long press from ON
        press(10, 10);
        check("on_mode", 32'(bus.mode_o), 32'd1);
        l0 = obs_long; p0 = obs_press; c0 = 32'(bus.press_count_o);
        bus.btn_i = 1'b1;
        repeat (40) tick();
        check("long_once", 32'(obs_long - l0), 32'd1);
        check("long_mode_held", 32'(bus.mode_o), 32'd0);
        bus.btn_i = 1'b0;
        repeat (12) tick();
        check("long_no_short", 32'(obs_press - p0), 32'd0);
        check("long_count", 32'(bus.press_count_o), 32'(c0));

        // 256 short presses wrap the counter
        do_reset();
        repeat (256) press(8, 10);
        check("wrap_count", 32'(bus.press_count_o), 32'd0);
        check("wrap_mode", 32'(bus.mode_o), 32'd1);

        // Enable dropped mid-press and restored before release
        p0 = obs_press; md0 = 32'(bus.mode_o);
        bus.btn_i = 1'b1;
        repeat (8) tick();
        bus.enable_i = 1'b0;
        repeat (3) tick();
        bus.enable_i = 1'b1;
        repeat (2) tick();
        bus.btn_i = 1'b0;
        repeat (10) tick();
        check("en_cancel_pulse", 32'(obs_press - p0), 32'd0);
        check("en_cancel_mode", 32'(bus.mode_o), 32'(md0));

        // Reset mid-BLINK with the button still held
        press(8, 12);
        check("blink_before_rst", 32'(bus.mode_o), 32'd2);
        bus.btn_i = 1'b1;
        repeat (8) tick();
        do_reset();
        check("rst_led", 32'(bus.led_o), 32'd0);
        check("rst_count", 32'(bus.press_count_o), 32'd0);
        repeat (5) tick();
        check("fresh_db_5", 32'(bus.btn_db_o), 32'd0);
        tick();
        check("fresh_db_6", 32'(bus.btn_db_o), 32'd1);
        repeat (4) tick();
        bus.btn_i = 1'b0;
        repeat (10) tick();
        check("fresh_press_mode", 32'(bus.mode_o), 32'd1);

        // Randomised stretches of button level and enable
        for (int i = 0; i < 300; i++) begin
            bus.btn_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) bus.enable_i = ~bus.enable_i;
            repeat ($urandom_range(1, 30)) tick();
        end
        bus.enable_i = 1'b1;
        bus.btn_i    = 1'b0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_ctrl.md
Name: button_ctrl

Overview:
Debounced push-button controller for the user-area button/LED pins. Raw button from io_in is synchronised, debounced and classified as short or long press. A mode state machine OFF/ON/BLINK drives three replicated LED outputs. Press events and a wrapping press counter are exported for the LA and IRQ lines in the user project top.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive cycles of disagreement before debounced level changes (>=2)
LONG_PRESS_CYCLES, 25000000, held cycles (debounced) that constitute a long press (> DEBOUNCE_CYCLES)
BLINK_HALF_CYCLES, 5000000, cycles per blink half-period (>=2)

Ports:
wb_clk_i  input  1  system clock, sole clock domain
wb_rst_i  input  1  reset, asynchronous assert, active-low (0 = reset); synchronous deassert handled at top
enable_i  input  1  controller enable (from LA); 0 freezes mode and suppresses events
btn_i  input  1  raw asynchronous button level, 1 = pressed
led_o  output  3  LED drive, all three bits identical
mode_o  output  2  current mode: 0 OFF, 1 ON, 2 BLINK (3 never produced)
press_pulse_o  output  1  one-cycle strobe on qualified short press
long_pulse_o  output  1  one-cycle strobe on qualified long press
press_count_o  output  8  count of short presses, wraps 255->0
btn_db_o  output  1  debounced button level

Behaviour:
- Reset (wb_rst_i=0): sync flops, btn_db, all counters 0; mode OFF; led_o=3'b000; pulses 0; press_count_o=0; blink phase 0.
- Synchroniser: two flops, btn_s = second stage.
- Debounce: db_cnt increments each cycle btn_s != btn_db; cleared when equal. When db_cnt == DEBOUNCE_CYCLES-1 and still unequal: btn_db <= btn_s, db_cnt <= 0. A glitch shorter than DEBOUNCE_CYCLES never changes btn_db. btn_db therefore flips at edge N+2+DEBOUNCE_CYCLES for btn_i stable from edge N.
- Hold counter: cleared on btn_db rising edge (btn_db=1, btn_db_q=0); increments while btn_db=1; saturates at LONG_PRESS_CYCLES.
- Long press: when hold reaches LONG_PRESS_CYCLES-1 while held and enable_i=1, long_pulse_o=1 next cycle (once per press), mode <= OFF on same edge. Release after a long press produces no short-press event.
- Short press: on btn_db falling edge with hold < LONG_PRESS_CYCLES-1 and enable_i=1: press_pulse_o=1 next cycle, press_count_o+1 (mod 256), mode advances OFF->ON->BLINK->OFF on same edge.
- Pulses registered, exactly one cycle wide, never both in same cycle.
- enable_i=0: mode, press_count_o held; no pulses; debounce and btn_db_o keep running. enable_i falling mid-press: the press is cancelled (no event at release, even if enable_i returns before release). A press is valid only if enable_i=1 at its btn_db rising edge and at the event.
- LED: OFF -> 000; ON -> 111; BLINK -> {3{phase}}. Entering BLINK sets phase=1, blink_cnt=0; phase toggles when blink_cnt == BLINK_HALF_CYCLES-1 (cnt then 0). blink_cnt/phase held at 0 outside BLINK.
- Reset asserted mid-press or mid-blink: all state returns to reset values immediately; a still-held button after reset release must debounce fresh (btn_db rises after 2+DEBOUNCE_CYCLES) and counts as a new press.

Test Plan:
(Params DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16, BLINK_HALF_CYCLES=8, enable_i=1 unless stated.)
- Reset, then btn_i pulses high 3 cycles -> btn_db_o stays 0, no pulses, mode_o=0, led_o=000.
- btn_i high 10 cycles then low -> btn_db_o rises 6 cycles after assert; on release press_pulse_o one cycle, mode_o=1, led_o=111, press_count_o=1.
- Two more short presses -> mode_o 2 then 0; in BLINK led_o=111 for 8 cycles, 000 for 8, repeating; press_count_o=3.
- Hold btn_i 40 cycles from mode ON -> long_pulse_o once, mode_o=0 while still held; release -> no press_pulse_o, press_count_o unchanged.
- 256 short presses -> press_count_o wraps to 0; mode_o = 256 mod 3 = 1.
- enable_i dropped during a press then restored before release -> no pulse, mode unchanged; wb_rst_i=0 mid-BLINK -> led_o=000, mode_o=0, count 0 immediately.
